if_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core. It generates fetch addresses, drives a request/grant/response instruction-memory interface, and buffers returned words in a small prefetch FIFO. It presents one registered instruction and its PC per cycle to the decode stage, and applies PC redirects requested by decode (JAL/JALR) and by the branch-resolution stage. All outstanding fetches belonging to the old stream are flushed and their late responses discarded.

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues fetch requests, buffers responses in a small
// prefetch FIFO and feeds one registered instruction/PC per cycle to decode.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic [1:0]  pc_mux_i,
  input  logic [31:0] jal_addr_i,
  input  logic [31:0] branch_addr_i,
  input  logic        id_ready_i,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_id_o,
  output logic        instr_valid_id_o
);
  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   r_fetch_addr, r_rsp_pc;
  logic [CW-1:0] r_outstanding, r_discard, r_count;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_id_instr, r_id_pc;
  logic          r_id_valid;

  logic          w_redirect, w_room, w_can_req, w_gnt;
  logic          w_acc, w_empty, w_full, w_push, w_pop, w_bypass;
  logic [31:0]   w_target;
  logic [CW-1:0] w_out_next;

  assign w_redirect = r_id_valid && (pc_mux_i == 2'b01 || pc_mux_i == 2'b10);
  assign w_target   = ((pc_mux_i == 2'b01) ? jal_addr_i : branch_addr_i) & 32'hFFFF_FFFC;

  // Capacity counts both in-flight and buffered words so a push can never overflow.
  assign w_room     = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_W;
  assign w_can_req  = rst_ni && w_room;
  assign w_gnt      = instr_gnt_i && w_can_req;

  assign instr_req_o  = w_can_req && !w_redirect;
  assign instr_addr_o = r_fetch_addr;

  assign w_acc      = instr_rvalid_i && (r_discard == '0) && !w_redirect;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_N);
  assign w_pop      = !w_redirect && id_ready_i && !w_empty;
  assign w_bypass   = w_acc && id_ready_i && w_empty;
  assign w_push     = w_acc && !w_bypass;
  assign w_out_next = r_outstanding + CW'(w_gnt) - CW'(instr_rvalid_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_addr  <= BOOT_ADDR;
      r_rsp_pc      <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        r_fetch_addr <= w_target;
        r_rsp_pc     <= w_target;
        // Everything still in flight belongs to the old stream.
        r_discard    <= w_out_next;
      end else begin
        if (w_gnt) r_fetch_addr <= r_fetch_addr + 32'd4;
        if (w_acc) r_rsp_pc     <= r_rsp_pc + 32'd4;
        if (instr_rvalid_i && r_discard != '0) r_discard <= r_discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]    <= r_rsp_pc;
      r_fifo_instr[r_wptr] <= instr_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_instr <= NOP;
      r_id_pc    <= BOOT_ADDR;
      r_id_valid <= 1'b0;
    end else if (w_redirect) begin
      r_id_instr <= NOP;
      r_id_valid <= 1'b0;
    end else if (id_ready_i) begin
      if (!w_empty) begin
        r_id_instr <= r_fifo_instr[r_rptr];
        r_id_pc    <= r_fifo_pc[r_rptr];
        r_id_valid <= 1'b1;
      end else if (w_acc) begin
        r_id_instr <= instr_rdata_i;
        r_id_pc    <= r_rsp_pc;
        r_id_valid <= 1'b1;
      end else begin
        r_id_instr <= NOP;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign instr_rdata_id_o = r_id_instr;
  assign pc_id_o          = r_id_pc;
  assign instr_valid_id_o = r_id_valid;

  ap_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full));

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vector bench for if_stage; memory responses (data = address)
// and all expected outputs are written out by hand in the table.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid, id_ready, vld;
  logic [31:0] addr, rdata, jal, br, instr_id, pc_id;
  logic [1:0]  mux;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .pc_mux_i(mux), .jal_addr_i(jal), .branch_addr_i(br),
    .id_ready_i(id_ready),
    .instr_rdata_id_o(instr_id), .pc_id_o(pc_id), .instr_valid_id_o(vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic [1:0]  mux;
    logic [31:0] jal, br;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic g, logic r, logic [31:0] d, logic [1:0] m,
                              logic [31:0] j, logic [31:0] b, logic rdy,
                              logic erq, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rv = r; v.rdata = d; v.mux = m; v.jal = j; v.br = b; v.rdy = rdy;
    v.ereq = erq; v.eaddr = ea; v.evld = ev; v.epc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    gnt = v.gnt; rvalid = v.rv; rdata = v.rdata; mux = v.mux;
    jal = v.jal; br = v.br; id_ready = v.rdy;
  endtask

  task automatic chk_outs(input int cyc, input logic erq, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ep);
    chk("req",   cyc, {31'd0, req}, {31'd0, erq});
    chk("addr",  cyc, addr, ea);
    chk("valid", cyc, {31'd0, vld}, {31'd0, ev});
    chk("pc_id", cyc, pc_id, ep);
    chk("instr", cyc, instr_id, ev ? ep : 32'h0000_0013);
  endtask

  initial begin
    // sequential fetch, zero-wait memory
    vecs.push_back(mk(1,0,32'h0,       0,0,0,1, 1,32'h0,   0,32'h0));
    vecs.push_back(mk(1,1,32'h0,       0,0,0,1, 1,32'h4,   0,32'h0));
    vecs.push_back(mk(1,1,32'h4,       0,0,0,1, 1,32'h8,   1,32'h0));
    vecs.push_back(mk(1,1,32'h8,       0,0,0,1, 1,32'hC,   1,32'h4));
    // decode stall for five cycles, FIFO fills, request drops
    vecs.push_back(mk(1,1,32'hC,       0,0,0,0, 1,32'h10,  1,32'h8));
    vecs.push_back(mk(0,1,32'h10,      0,0,0,0, 0,32'h14,  1,32'h8));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0, 0,32'h14,  1,32'h8));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0, 0,32'h14,  1,32'h8));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,0, 0,32'h14,  1,32'h8));
    vecs.push_back(mk(0,0,32'h0,       0,0,0,1, 0,32'h14,  1,32'h8));
    vecs.push_back(mk(1,0,32'h0,       0,0,0,1, 1,32'h14,  1,32'hC));
    vecs.push_back(mk(1,1,32'h14,      0,0,0,1, 1,32'h18,  1,32'h10));
    // two in flight, then JAL to 0x100
    vecs.push_back(mk(1,0,32'h0,       0,0,0,0, 1,32'h1C,  1,32'h14));
    vecs.push_back(mk(0,0,32'h0,       1,32'h100,0,1, 0,32'h20, 1,32'h14));
    vecs.push_back(mk(0,1,32'h18,      0,0,0,1, 0,32'h100, 0,32'h14));
    vecs.push_back(mk(1,1,32'h1C,      0,0,0,1, 1,32'h100, 0,32'h14));
    vecs.push_back(mk(1,1,32'h100,     0,0,0,1, 1,32'h104, 0,32'h14));
    vecs.push_back(mk(1,1,32'h104,     0,0,0,1, 1,32'h108, 1,32'h100));
    // branch to 0x40 with gnt and rvalid in the same cycle
    vecs.push_back(mk(1,1,32'h108,     2,0,32'h40,1, 0,32'h10C, 1,32'h104));
    vecs.push_back(mk(1,1,32'h10C,     0,0,0,1, 1,32'h40,  0,32'h104));
    vecs.push_back(mk(1,1,32'h40,      0,0,0,1, 1,32'h44,  0,32'h104));
    // pc_mux 11 and 01-while-bubble are ignored
    vecs.push_back(mk(1,1,32'h44,      3,32'h200,32'h300,1, 1,32'h48, 1,32'h40));
    vecs.push_back(mk(1,0,32'h0,       0,0,0,1, 1,32'h4C,  1,32'h44));
    vecs.push_back(mk(0,1,32'h48,      1,32'h200,0,1, 0,32'h50, 0,32'h44));
    vecs.push_back(mk(1,1,32'h4C,      0,0,0,1, 1,32'h50,  1,32'h48));
    // unaligned branch target near top of memory, wrap to zero
    vecs.push_back(mk(0,0,32'h0,       2,0,32'hFFFF_FFFB,1, 0,32'h54, 1,32'h4C));
    vecs.push_back(mk(1,1,32'h50,      0,0,0,1, 1,32'hFFFF_FFF8, 0,32'h4C));
    vecs.push_back(mk(1,1,32'hFFFF_FFF8,0,0,0,1, 1,32'hFFFF_FFFC, 0,32'h4C));
    vecs.push_back(mk(1,1,32'hFFFF_FFFC,0,0,0,1, 1,32'h0,  1,32'hFFFF_FFF8));
    vecs.push_back(mk(1,1,32'h0,       0,0,0,1, 1,32'h4,   1,32'hFFFF_FFFC));
    vecs.push_back(mk(1,0,32'h0,       0,0,0,0, 1,32'h8,   1,32'h0));

    rst_n = 1'b0; gnt = 0; rvalid = 0; rdata = 0; mux = 0; jal = 0; br = 0; id_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_outs(-1, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      chk_outs(i, vecs[i].ereq, vecs[i].eaddr, vecs[i].evld, vecs[i].epc);
      @(posedge clk);
      #1;
    end

    // two fetches in flight (addresses 4 and 8): capacity exhausted
    gnt = 0; rvalid = 0; mux = 0; id_ready = 0;
    #2;
    chk("req_full", 100, {31'd0, req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_outs(101, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; gnt = 1; id_ready = 1;
    #3;
    chk_outs(102, 1'b1, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    gnt = 0;
    #3;
    chk("addr_after_rst", 103, addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
